// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Imported by the controller and its single-step datapath.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PREP = 2'b01,
        RUN  = 2'b10,
        FIX  = 2'b11
    } state_e;

    function automatic logic op_is_div(input op_e o);
        return (o == DIV) || (o == DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return (o == MULT) || (o == DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer: LSB-first shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     opnd,
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;

    // Divide keeps {remainder, dividend/quotient}; the remainder always stays
    // below the divisor, so the subtract result fits in XLEN bits.
    always_comb begin
        add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff     = rem_sh[XLEN-1:0] - opnd;
        acc_next = {add_sum, acc[XLEN-1:1]};
        if (is_div) begin
            if (rem_sh >= {1'b0, opnd}) begin
                acc_next = {diff, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer owning HI/LO: IDLE -> PREP -> RUN(ITER) -> FIX,
// with the ID-stage stall for HI/LO accesses or a new op while busy.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN = muldiv_pkg::XLEN,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    input  logic            rd_hi,
    input  logic            rd_lo,
    input  logic            cancel,
    output logic            busy,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            done,
    output logic            div_by_zero,
    output state_e          state_dbg
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    state_e            state_q, state_d;
    op_e               op_q;
    logic [XLEN-1:0]   rs_q, rt_q, opnd_q;
    logic [2*XLEN-1:0] acc_q, acc_step;
    logic [CNT_W-1:0]  cnt_q;
    logic              sign_quo, sign_rem;

    logic              is_div, signed_op, rs_neg, rt_neg, div0;
    logic [XLEN-1:0]   rs_mag, rt_mag, quo, rem, hi_res, lo_res;
    logic [2*XLEN-1:0] prod_neg;

    assign is_div    = op_is_div(op_q);
    assign signed_op = op_is_signed(op_q);
    assign rs_neg    = signed_op & rs_q[XLEN-1];
    assign rt_neg    = signed_op & rt_q[XLEN-1];
    assign rs_mag    = rs_neg ? -rs_q : rs_q;
    assign rt_mag    = rt_neg ? -rt_q : rt_q;
    assign div0      = is_div && (rt_q == '0);

    // Handshake: start/mthi/mtlo/rd_hi/rd_lo are offered by decode each cycle;
    // while busy they are refused and stall is raised, and decode holds the
    // request until busy falls, where it is taken on the next edge.
    assign busy      = (state_q != IDLE);
    assign stall     = busy & (start | mthi | mtlo | rd_hi | rd_lo);
    assign state_dbg = state_q;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div   (is_div),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (acc_step)
    );

    assign quo      = acc_q[XLEN-1:0];
    assign rem      = acc_q[2*XLEN-1:XLEN];
    assign prod_neg = -acc_q;

    always_comb begin
        hi_res = sign_quo ? prod_neg[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        lo_res = sign_quo ? prod_neg[XLEN-1:0] : acc_q[XLEN-1:0];
        if (is_div) begin
            lo_res = sign_quo ? -quo : quo;
            hi_res = sign_rem ? -rem : rem;
            // Division by zero returns the original dividend, sign untouched.
            if (div0) begin
                hi_res = rs_q;
                lo_res = XLEN'(DIV0_LO);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = PREP;
            PREP:    state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(ITER - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (cancel && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= MULT;
            rs_q        <= '0;
            rt_q        <= '0;
            opnd_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sign_quo    <= 1'b0;
            sign_rem    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q <= op_e'(op);
                        rs_q <= rs_val;
                        rt_q <= rt_val;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                PREP: begin
                    sign_quo <= rs_neg ^ rt_neg;
                    sign_rem <= rs_neg;
                    cnt_q    <= '0;
                    // Upper half starts cleared; lower half holds the bits consumed per step.
                    if (is_div) begin
                        acc_q  <= {{XLEN{1'b0}}, rs_mag};
                        opnd_q <= rt_mag;
                    end else begin
                        acc_q  <= {{XLEN{1'b0}}, rt_mag};
                        opnd_q <= rs_mag;
                    end
                end
                RUN: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    if (!cancel) begin
                        hi          <= hi_res;
                        lo          <= lo_res;
                        done        <= 1'b1;
                        div_by_zero <= div0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: expected HI/LO/div_by_zero pushed at issue,
// popped and compared by a monitor whenever done pulses.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int W = 2 * XLEN + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start, mthi, mtlo, rd_hi, rd_lo, cancel;
    logic [1:0]      op;
    logic [XLEN-1:0] rs_val, rt_val, wdata;
    logic            busy, stall, done, div_by_zero;
    logic [XLEN-1:0] hi, lo;
    state_e          state_dbg;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    muldiv_ctrl #(.XLEN(XLEN), .ITER(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .rd_hi(rd_hi), .rd_lo(rd_lo),
        .cancel(cancel), .busy(busy), .stall(stall), .hi(hi), .lo(lo), .done(done),
        .div_by_zero(div_by_zero), .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: hi=0x%0h lo=0x%0h dbz=%0b", hi, lo, div_by_zero);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({div_by_zero, hi, lo} !== e) begin
                    n_fail++;
                    $display("FAIL result: got dbz=%0b hi=0x%0h lo=0x%0h expected dbz=%0b hi=0x%0h lo=0x%0h",
                             div_by_zero, hi, lo, e[W-1], e[2*XLEN-1:XLEN], e[XLEN-1:0]);
                end
            end
        end
        if (div_by_zero && !done) begin
            n_checks++;
            n_fail++;
            $display("FAIL dbz_without_done: got dbz=1 done=0 expected dbz=0");
        end
    end

    // driver tasks
    task automatic wait_done(output int cyc, output int bcyc);
        bit got;
        cyc = 0; bcyc = 0; got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (busy) bcyc++;
            if (done) got = 1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done within 60 cycles expected done");
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] eh,
                          input logic [XLEN-1:0] el, input logic ez);
        int cyc, bcyc;
        exp_q.push_back({ez, eh, el});
        issue(o, a, b);
        wait_done(cyc, bcyc);
        check({name, "_latency"}, 64'(cyc), 64'd35);
        check({name, "_busy_cycles"}, 64'(bcyc), 64'd34);
    endtask

    initial begin
        int cyc, bcyc, stall_cnt, done_cnt;
        bit got;
        rst = 1'b1; start = 0; mthi = 0; mtlo = 0; rd_hi = 0; rd_lo = 0; cancel = 0;
        op = 2'b00; rs_val = '0; rt_val = '0; wdata = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_lo", 64'(lo), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_dbz", 64'(div_by_zero), 64'h0);
        check("rst_stall", 64'(stall), 64'h0);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // arithmetic, issued back-to-back in each done cycle
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        run_op("div_neg_zero", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

        // rd_lo 3 cycles after start stalls until the done cycle
        exp_q.push_back({1'b0, 32'h0, 32'd42});
        issue(2'b01, 32'd6, 32'd7);
        repeat (3) @(posedge clk);
        #1 rd_lo = 1'b1;
        stall_cnt = 0; got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (i == 0) check("rd_lo_old_value", 64'(lo), 64'hFFFF_FFFF);
            if (done) got = 1;
            else if (stall) stall_cnt++;
        end
        check("rd_lo_stall_cycles", 64'(stall_cnt), 64'd31);
        check("rd_lo_stall_released", 64'(stall), 64'h0);
        check("rd_lo_new_value", 64'(lo), 64'd42);
        rd_lo = 1'b0;

        // idle mthi, then mthi held during busy
        @(posedge clk);
        #1 mthi = 1'b1; wdata = 32'h1111_1111;
        @(posedge clk);
        #1 mthi = 1'b0;
        check("idle_mthi", 64'(hi), 64'h1111_1111);
        exp_q.push_back({1'b0, 32'h0, 32'd6});
        issue(2'b01, 32'd2, 32'd3);
        repeat (4) @(posedge clk);
        #1 mthi = 1'b1; wdata = 32'hABCD_1234;
        @(negedge clk);
        check("busy_mthi_stall", 64'(stall), 64'h1);
        check("busy_mthi_not_written", 64'(hi), 64'h1111_1111);
        wait_done(cyc, bcyc);
        check("mthi_stall_released", 64'(stall), 64'h0);
        @(posedge clk);
        #1 mthi = 1'b0;
        check("mthi_after_idle_hi", 64'(hi), 64'hABCD_1234);
        check("mthi_after_idle_lo", 64'(lo), 64'd6);

        // start and mtlo together: mtlo dropped
        exp_q.push_back({1'b0, 32'h0, 32'd20});
        mtlo = 1'b1; wdata = 32'h0000_DEAD;
        issue(2'b01, 32'd4, 32'd5);
        mtlo = 1'b0;
        @(negedge clk);
        check("start_mtlo_dropped", 64'(lo), 64'd6);
        wait_done(cyc, bcyc);
        @(posedge clk);
        #1;

        // cancel on RUN cycle 10
        issue(2'b01, 32'd9, 32'd9);
        repeat (11) @(posedge clk);
        #1 cancel = 1'b1;
        @(negedge clk);
        check("cancel_busy_before", 64'(busy), 64'h1);
        @(posedge clk);
        #1 cancel = 1'b0;
        check("cancel_busy_after", 64'(busy), 64'h0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("cancel_no_done", 64'(done_cnt), 64'h0);
        check("cancel_hi_kept", 64'(hi), 64'h0);
        check("cancel_lo_kept", 64'(lo), 64'd20);

        // asynchronous reset mid-RUN
        @(posedge clk);
        #1;
        issue(2'b01, 32'd3, 32'd3);
        repeat (15) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_hi", 64'(hi), 64'h0);
        check("arst_lo", 64'(lo), 64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_state", 64'(state_dbg), 64'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op("mult_after_rst", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'd1, 1'b0);

        @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer for the R2000 pipeline. It owns the HI/LO register pair and executes MULT/MULTU/DIV/DIVU over a fixed 35-cycle schedule using one shift-add/subtract step per cycle. It generates the ID-stage stall when a later HI/LO access, or a second mult/div, arrives while an operation is in flight. It sits beside the ID/EX boundary; the stall output is ORed into the decode hold_pc/hold_if/control-bubble path.

## Interface
Parameters:
- XLEN, 32: operand and HI/LO width.
- ITER, XLEN: RUN-state iterations, one bit per cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  issue the mult/div held in op; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_val  in  XLEN  multiplicand / dividend.
- rt_val  in  XLEN  multiplier / divisor.
- mthi, mtlo  in  1  write wdata into HI / LO.
- wdata  in  XLEN  MTHI/MTLO data.
- rd_hi, rd_lo  in  1  MFHI / MFLO request from decode.
- cancel  in  1  abort the in-flight operation; HI/LO are left unchanged.
- busy  out  1  high in PREP, RUN and FIX.
- stall  out  1  combinational: busy & (start | mthi | mtlo | rd_hi | rd_lo).
- hi, lo  out  XLEN  registered HI/LO values; read combinationally by decode.
- done  out  1  one-cycle pulse when HI/LO take a result.
- div_by_zero  out  1  pulse coincident with done for DIV/DIVU with rt_val == 0.

## Operation
State machine: IDLE → PREP → RUN → FIX → IDLE.

IDLE:
- start: latch op, rs_val and rt_val; go to PREP.
- Else mthi/mtlo: write HI/LO on that edge.
- start has priority over mthi/mtlo in the same cycle; mthi/mtlo are then dropped.
- rd_hi/rd_lo need no action.

PREP:
- Signed ops (MULT, DIV): convert operands to magnitudes; record sign_q = sign(rs)^sign(rt) and sign_r = sign(rs).
- Unsigned ops: both signs are 0.
- Clear the 2·XLEN accumulator and the 5-bit counter.

RUN, ITER cycles:
- Multiply: LSB-first shift-add into a 64-bit product.
- Divide: restoring shift-subtract; quotient bit = 1 when the trial remainder is ≥ 0.
- After the counter reaches ITER-1, go to FIX.

FIX:
- Negate the product if sign_q is set.
- For divide, negate the quotient if sign_q and the remainder if sign_r.
- Division by zero (divisor == 0): force HI = original rs_val and LO = 32'hFFFFFFFF, regardless of sign.
- DIV 0x80000000 / 0xFFFFFFFF wraps: LO = 0x80000000, HI = 0.
- Commit HI/LO on the FIX→IDLE edge.

Rules applying in every state:
- cancel in PREP/RUN/FIX: go to IDLE on the next edge; no commit, no done.
- cancel in IDLE is ignored.
- start/mthi/mtlo while busy are not accepted. Decode holds them via stall and retries them once busy falls.
- Multiply results: HI = product[63:32], LO = product[31:0]. Divide results: LO = quotient, HI = remainder.

## Timing
- Let start be sampled at edge E0. Then PREP runs E0→E1, RUN covers E1..E33 (32 cycles), FIX ends at E34.
- busy is high from after E0 until E34. HI/LO are valid and done = 1 in the cycle after E34, giving 35-cycle latency.
- A new start is accepted in that same cycle, giving back-to-back throughput of 35 cycles.
- An rd_hi/rd_lo issued during busy stalls until the done cycle, then reads the new value with no bypass.
- Reset values:
  - state = IDLE.
  - hi, lo = 0.
  - busy, done, div_by_zero = 0, and therefore stall = 0.
  - counter and accumulator = 0.
- Asynchronous reset mid-operation discards the operation immediately.

## Structure
- Package muldiv_pkg holds:
  - XLEN;
  - the op_e enum (MULT, MULTU, DIV, DIVU);
  - the state_e enum (IDLE, PREP, RUN, FIX);
  - the DIV0_LO = 32'hFFFFFFFF constant.
- One combinational sub-module, muldiv_step, performs a single add-shift or subtract-shift iteration.
- The FSM, counter, sign logic, HI/LO registers and stall logic stay in muldiv_ctrl.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → done 35 cycles after start; HI = 0xFFFFFFFE, LO = 0x00000001; busy high for exactly 34 cycles.
- MULT −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 5 / 0 → HI = 5, LO = 0xFFFFFFFF; div_by_zero and done pulse together. DIV −5 / 0 → HI = 0xFFFFFFFB, LO = 0xFFFFFFFF.
- Hazard sequence:
  - rd_lo asserted 3 cycles after start → stall = 1 until the done cycle, then lo shows the new result.
  - mthi during busy → stalled, then written after idle.
  - start and mtlo in the same idle cycle → mtlo dropped.
- cancel on RUN cycle 10 → busy = 0 next cycle, no done, HI/LO unchanged. Then rst asserted mid-RUN of a new op → hi = lo = 0 and busy = 0 immediately, without waiting for a clock edge.
